// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial ALU sequencer driving an external 1-bit ALU, LSB first
// Optional zero-result flag output enabled by SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             alu_op_a,
    output logic             alu_op_b,
    output logic             alu_cin,
    output logic [3:0]       alu_opcode,
    input  logic             alu_result,
    input  logic             alu_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        alu_op_a = 1'b0;
        alu_op_b = 1'b0;
        alu_cin  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opcode_d = opcode;
                    a_d      = a;
                    b_d      = b;
                    // carry register doubles as the bit-0 carry-in
                    carry_d  = cin;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                alu_op_a = a_q[0];
                alu_op_b = b_q[0];
                alu_cin  = carry_q;
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                carry_d  = alu_cout;
                res_sh_d = {alu_result, res_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = res_sh_d;
                    cout_d   = alu_cout;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                    zero_d   = (res_sh_d == '0);
`endif
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            res_sh_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign result     = result_q;
    assign cout       = cout_q;
    assign alu_opcode = opcode_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    assign zero       = zero_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb/tb_serial_alu_ctrl.sv - directed self-checking bench for serial_alu_ctrl with a 1-bit ALU model
module tb_serial_alu_ctrl;

    localparam int W = 8;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_XOR  = 4'h1;
    localparam logic [3:0] OP_ADDC = 4'h2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   opcode = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] result;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic         zero;
`endif
    logic         alu_op_a, alu_op_b, alu_cin;
    logic [3:0]   alu_opcode;
    logic         alu_result, alu_cout;

    int n_pass = 0;
    int n_total = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        .zero(zero),
`endif
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_cin(alu_cin),
        .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 1'b0;
        alu_cout   = 1'b0;
        case (alu_opcode)
            OP_ADD, OP_ADDC: begin
                alu_result = alu_op_a ^ alu_op_b ^ alu_cin;
                alu_cout   = (alu_op_a & alu_op_b) | (alu_cin & (alu_op_a ^ alu_op_b));
            end
            OP_XOR:  alu_result = alu_op_a ^ alu_op_b;
            default: alu_result = 1'b0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic launch(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        opcode = op; a = av; b = bv; cin = c; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if ({busy, done, result, cout} !== '0) $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b, required all 0", busy, done, result, cout);
        else n_pass++;
        n_total++;
        if ({alu_op_a, alu_op_b, alu_cin, alu_opcode} !== 7'b0) $display("FAIL reset_alu_drive: got %b%b%b op=%h, required 0", alu_op_a, alu_op_b, alu_cin, alu_opcode);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        int c; bit seen;
        launch(OP_ADD, 8'h0F, 8'h01, 1'b0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL add_busy: got %b, required 1", busy);
        else n_pass++;
        wait_done(20, c, seen);
        n_total++;
        if (!seen || c + 1 != 9) $display("FAIL add_latency: got seen=%0d cycles=%0d, required 9", seen, c + 1);
        else n_pass++;
        n_total++;
        if (result !== 8'h10 || cout !== 1'b0) $display("FAIL add_result: got %h/%b, required 10/0", result, cout);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h10) $display("FAIL add_after_done: got done=%b busy=%b result=%h, required 0 0 10", done, busy, result);
        else n_pass++;
    endtask

    task automatic test_addc();
        int c; bit seen;
        launch(OP_ADDC, 8'hFF, 8'h00, 1'b1);
        n_total++;
        if (alu_cin !== 1'b1) $display("FAIL addc_cin_bit0: got %b, required 1", alu_cin);
        else n_pass++;
        step();
        n_total++;
        if (alu_cin !== 1'b1) $display("FAIL addc_cin_bit1: got %b, required 1", alu_cin);
        else n_pass++;
        wait_done(20, c, seen);
        n_total++;
        if (!seen || result !== 8'h00 || cout !== 1'b1) $display("FAIL addc_result: got seen=%0d %h/%b, required 00/1", seen, result, cout);
        else n_pass++;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        n_total++;
        if (zero !== 1'b1) $display("FAIL addc_zero: got %b, required 1", zero);
        else n_pass++;
`endif
        step();
    endtask

    task automatic test_xor();
        logic [W-1:0] seq;
        launch(OP_XOR, 8'hA5, 8'hFF, 1'b1);
        n_total++;
        if (alu_opcode !== OP_XOR || alu_cin !== 1'b1) $display("FAIL xor_drive_bit0: got op=%h cin=%b, required 1/1", alu_opcode, alu_cin);
        else n_pass++;
        for (int k = 0; k < W; k++) begin
            seq[k] = alu_op_a;
            if (k < W - 1) step();
        end
        n_total++;
        if (seq !== 8'hA5) $display("FAIL xor_op_a_seq: got %b (LSB first), required 10100101", seq);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b1 || result !== 8'h5A) $display("FAIL xor_result: got done=%b result=%h, required 1/5a", done, result);
        else n_pass++;
        n_total++;
        if (alu_op_a !== 1'b0 || alu_op_b !== 1'b0 || alu_cin !== 1'b0 || alu_opcode !== OP_XOR) $display("FAIL xor_idle_drive: got %b%b%b op=%h, required 000 op=1", alu_op_a, alu_op_b, alu_cin, alu_opcode);
        else n_pass++;
        step();
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        launch(OP_ADD, 8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (i == 3) begin start = 1'b1; a = 8'h00; b = 8'h00; end
            if (i == 4) start = 1'b0;
            step();
            if (done) ndone++;
        end
        n_total++;
        if (ndone != 1) $display("FAIL ignore_done_count: got %0d, required 1", ndone);
        else n_pass++;
        n_total++;
        if (result !== 8'h10) $display("FAIL ignore_result: got %h, required 10", result);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c; bit seen; int ndone = 0;
        launch(OP_ADD, 8'hFF, 8'h01, 1'b0);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || cout !== 1'b0 || alu_op_a !== 1'b0) $display("FAIL midreset_outputs: got busy=%b done=%b result=%h cout=%b op_a=%b, required all 0", busy, done, result, cout, alu_op_a);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) ndone++;
        end
        n_total++;
        if (ndone != 0) $display("FAIL midreset_no_done: got %0d, required 0", ndone);
        else n_pass++;
        rst_n = 1'b1;
        launch(OP_XOR, 8'h3C, 8'h0F, 1'b0);
        wait_done(20, c, seen);
        n_total++;
        if (!seen || c + 1 != 9 || result !== 8'h33 || cout !== 1'b0) $display("FAIL midreset_recover: got seen=%0d lat=%0d %h/%b, required 9 33/0", seen, c + 1, result, cout);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        int times[$];
        opcode = OP_ADD; a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        for (int t = 1; t <= 35; t++) begin
            step();
            if (done) times.push_back(t);
        end
        start = 1'b0;
        n_total++;
        if (times.size() != 3) $display("FAIL b2b_count: got %0d, required 3", times.size());
        else n_pass++;
        n_total++;
        if (times.size() != 3 || times[0] != 9 || times[1] != 19 || times[2] != 29) $display("FAIL b2b_timing: got %p, required 9 19 29", times);
        else n_pass++;
        n_total++;
        if (result !== 8'h03) $display("FAIL b2b_result: got %h, required 03", result);
        else n_pass++;
        repeat (12) step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_addc();
        test_xor();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand/result word width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a new operation; sampled only in IDLE.
REQ-005 opcode  input  4  SHALL be the operation code (ADD, XOR, ADDC, ... from the shared opcode definitions), latched on accepted start.
REQ-006 a  input  WIDTH  SHALL be operand A, latched on accepted start.
REQ-007 b  input  WIDTH  SHALL be operand B, latched on accepted start.
REQ-008 cin  input  1  SHALL be the carry-in for bit 0, latched on accepted start.
REQ-009 busy  output  1  SHALL be high while an operation is in progress.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle when result is valid.
REQ-011 result  output  WIDTH  SHALL hold the last completed result.
REQ-012 cout  output  1  SHALL hold the carry out of the last completed operation's MSB.
REQ-013 alu_op_a, alu_op_b, alu_cin  output  1 each  SHALL drive the 1-bit ALU operand and carry inputs.
REQ-014 alu_opcode  output  4  SHALL drive the ALU opcode.
REQ-015 alu_result, alu_cout  input  1 each  SHALL receive the combinational ALU result bit and carry out.

Function
REQ-016 The controller SHALL use states IDLE, SHIFT, DONE.
REQ-017 IDLE: start=1 SHALL latch opcode/a/b/cin, clear the bit counter, and move to SHIFT next cycle; start=0 stays IDLE.
REQ-018 SHIFT SHALL last exactly WIDTH cycles, processing bit k (LSB first, k=0..WIDTH-1) in the k-th SHIFT cycle.
REQ-019 In SHIFT, alu_op_a/alu_op_b SHALL equal bit 0 of the internal right-shifting A/B registers; alu_opcode SHALL equal the latched opcode.
REQ-020 alu_cin SHALL equal the latched cin for bit 0 and the registered alu_cout of bit k-1 for bit k>0.
REQ-021 Each SHIFT cycle SHALL shift alu_result into the MSB of the result shift register and shift it right one place.
REQ-022 On the last SHIFT cycle, alu_cout SHALL be captured into cout and the assembled word into result; next state DONE.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE; total latency start-accepted to done = WIDTH+1 cycles.
REQ-024 busy SHALL be high in SHIFT and DONE, low in IDLE.
REQ-025 start asserted while busy=1 SHALL be ignored and SHALL NOT alter latched operands.
REQ-026 result and cout SHALL remain stable from done until the next operation's DONE cycle.
REQ-027 Outside SHIFT, alu_op_a, alu_op_b, alu_cin SHALL be driven 0 and alu_opcode SHALL hold the last latched value.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, cout=0, counter=0, all ALU drive outputs 0, alu_opcode=0.
REQ-029 Reset asserted mid-operation SHALL abandon it without a done pulse; result/cout SHALL read 0.
REQ-030 After rst_n rises, the first start SHALL be accepted on the first rising clk edge.

Configuration
REQ-031 With SERIAL_ALU_ZERO_FLAG_EN defined, an extra output zero (1 bit) SHALL be set at DONE to 1 iff the completed result is all zeros, held like result, reset to 0.
REQ-032 Without SERIAL_ALU_ZERO_FLAG_EN, the zero port and its logic SHALL not exist; all other behaviour is identical.

Verification
REQ-033 WIDTH=8, ADD a=0x0F b=0x01 cin=0 -> done 9 cycles after start, result=0x10, cout=0.
REQ-034 ADDC a=0xFF b=0x00 cin=1 -> result=0x00, cout=1, zero=1 (macro defined).
REQ-035 XOR a=0xA5 b=0xFF -> result=0x5A; alu_op_a sequence 1,0,1,0,0,1,0,1 across SHIFT cycles.
REQ-036 start pulsed in SHIFT cycle 3 with a=0x00 -> ignored; first result unchanged, no second done.
REQ-037 rst_n low in SHIFT cycle 4 -> busy=0, result=0, cout=0 immediately, no done pulse; new start then completes normally.
REQ-038 start held high continuously -> back-to-back operations, done every WIDTH+2 cycles.
